// File: rtl/alarm_pkg.sv
// ----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm arm/disarm sequencer and the alarm core.
//   seq_state_t  : sequencer state encodings, also visible on state_o
//   core_state_t : alarm core state encodings, kept here so both sides agree
//   timer_width  : bits needed to hold the largest (delay - 1) timer load
// ----------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED   = 3'd0,
        ST_EXIT_WAIT  = 3'd1,
        ST_ARMED      = 3'd2,
        ST_ENTRY_WAIT = 3'd3,
        ST_SIREN      = 3'd4,
        ST_LOCKED     = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        CORE_OFF       = 2'd0,
        CORE_ARMED     = 2'd1,
        CORE_TRIGGERED = 2'd2,
        CORE_ALARM_ON  = 2'd3
    } core_state_t;

    // Width that holds max_dly-1; never narrower than one bit.
    function automatic int timer_width(input int max_dly);
        return (max_dly < 2) ? 1 : $clog2(max_dly);
    endfunction

endpackage

// File: rtl/alarm_delay_timer.sv
// ----------------------------------------------------------------------------
// alarm_delay_timer
// Loadable down-counter shared by the exit, entry, siren and lockout periods.
// It saturates at zero and only reloads when i_load is pulsed.
//   clk, rst_n  : clock, synchronous active-low reset (count -> 0)
//   i_load      : load i_load_val this edge (wins over decrement)
//   i_load_val  : value to load
//   o_zero      : count is zero
// ----------------------------------------------------------------------------
module alarm_delay_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/alarm_arm_sequencer.sv
// ----------------------------------------------------------------------------
// alarm_arm_sequencer
// Keypad-driven arm/disarm controller in front of the alarm core. Adds exit and
// entry delays, a bounded siren period, per-zone masking and wrong-code lockout.
//   clk, rst_n           : clock, synchronous active-low reset
//   code_valid, code     : keypad entry strobe and value
//   secret               : configured code (static while in use)
//   zone, zone_mask      : raw sensor levels, 1 = zone enabled
//   arm_o, trig_o        : core arm / trigger levels
//   alarm_go, siren      : core alarm-confirm and siren drive (SIREN only)
//   lockout              : high while LOCKED
//   zone_hit             : latched zones that caused the trigger
//   bad_cnt              : consecutive wrong-code count
//   state_o              : current state encoding
//
// Handshake: code_valid is a one-cycle strobe with no back-pressure; the code
// is consumed on the edge where code_valid is high, except in LOCKED where it
// is dropped.
// ----------------------------------------------------------------------------
module alarm_arm_sequencer
    import alarm_pkg::*;
#(
    parameter int ZONES     = 4,
    parameter int CODE_W    = 4,
    parameter int EXIT_DLY  = 8,
    parameter int ENTRY_DLY = 8,
    parameter int SIREN_CYC = 16,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_CYC  = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           code_valid,
    input  logic [CODE_W-1:0]              code,
    input  logic [CODE_W-1:0]              secret,
    input  logic [ZONES-1:0]               zone,
    input  logic [ZONES-1:0]               zone_mask,
    output logic                           arm_o,
    output logic                           trig_o,
    output logic                           alarm_go,
    output logic                           siren,
    output logic                           lockout,
    output logic [ZONES-1:0]               zone_hit,
    output logic [$clog2(MAX_TRIES+1)-1:0] bad_cnt,
    output logic [2:0]                     state_o
);

    localparam int MAX_A   = (EXIT_DLY  > ENTRY_DLY) ? EXIT_DLY  : ENTRY_DLY;
    localparam int MAX_B   = (SIREN_CYC > LOCK_CYC)  ? SIREN_CYC : LOCK_CYC;
    localparam int MAX_DLY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W   = timer_width(MAX_DLY);
    localparam int BAD_W   = $clog2(MAX_TRIES+1);
    localparam logic [BAD_W-1:0] BAD_MAX = BAD_W'(MAX_TRIES);

    seq_state_t       r_state;
    logic [ZONES-1:0] r_zone_hit;
    logic [BAD_W-1:0] r_bad;
    logic             r_arm, r_trig, r_alarm_go, r_siren, r_lockout;

    seq_state_t       w_next;
    logic [ZONES-1:0] w_hit_next;
    logic [BAD_W-1:0] w_bad_next;
    logic [BAD_W-1:0] w_bad_inc;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_zero;
    logic             w_match;
    logic             w_wrong;
    logic             w_reach;
    logic [ZONES-1:0] w_zact;

    alarm_delay_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    assign w_match   = code_valid && (code == secret);
    assign w_wrong   = code_valid && (code != secret);
    assign w_zact    = zone & zone_mask;
    // Saturating increment so repeated wrong codes in SIREN stay at MAX_TRIES.
    assign w_bad_inc = (r_bad >= BAD_MAX) ? BAD_MAX : r_bad + 1'b1;
    assign w_reach   = (w_bad_inc == BAD_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_DISARMED;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_hit_next = r_zone_hit;
        w_bad_next = r_bad;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_DISARMED: begin
                if (w_match) begin
                    w_next     = ST_EXIT_WAIT;
                    w_load     = 1'b1;
                    w_load_val = TMR_W'(EXIT_DLY - 1);
                    w_bad_next = '0;
                end else if (w_wrong) begin
                    w_bad_next = w_bad_inc;
                    if (w_reach) begin
                        w_next     = ST_LOCKED;
                        w_load     = 1'b1;
                        w_load_val = TMR_W'(LOCK_CYC - 1);
                    end
                end
            end
            ST_EXIT_WAIT, ST_ARMED, ST_ENTRY_WAIT, ST_SIREN: begin
                if (w_match) begin
                    w_next     = ST_DISARMED;
                    w_bad_next = '0;
                    w_hit_next = '0;
                end else if (w_wrong && w_reach && (r_state != ST_SIREN)) begin
                    // Code-driven escalation outranks zone and timer events.
                    w_bad_next = w_bad_inc;
                    w_next     = ST_SIREN;
                    w_load     = 1'b1;
                    w_load_val = TMR_W'(SIREN_CYC - 1);
                end else begin
                    if (w_wrong) begin
                        w_bad_next = w_bad_inc;
                    end
                    case (r_state)
                        ST_EXIT_WAIT: begin
                            if (w_zero) begin
                                w_next = ST_ARMED;
                            end
                        end
                        ST_ARMED: begin
                            if (|w_zact) begin
                                w_next     = ST_ENTRY_WAIT;
                                w_load     = 1'b1;
                                w_load_val = TMR_W'(ENTRY_DLY - 1);
                                w_hit_next = r_zone_hit | w_zact;
                            end
                        end
                        ST_ENTRY_WAIT: begin
                            w_hit_next = r_zone_hit | w_zact;
                            if (w_zero) begin
                                w_next     = ST_SIREN;
                                w_load     = 1'b1;
                                w_load_val = TMR_W'(SIREN_CYC - 1);
                            end
                        end
                        default: begin
                            // SIREN: a still-active zone re-triggers from ARMED.
                            if (w_zero) begin
                                w_next = ST_ARMED;
                            end
                        end
                    endcase
                end
            end
            ST_LOCKED: begin
                if (w_zero) begin
                    w_next     = ST_DISARMED;
                    w_bad_next = '0;
                end
            end
            default: begin
                w_next = ST_DISARMED;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_o.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zone_hit <= '0;
            r_bad      <= '0;
            r_arm      <= 1'b0;
            r_trig     <= 1'b0;
            r_alarm_go <= 1'b0;
            r_siren    <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_zone_hit <= w_hit_next;
            r_bad      <= w_bad_next;
            r_arm      <= (w_next == ST_ARMED) || (w_next == ST_ENTRY_WAIT) ||
                          (w_next == ST_SIREN);
            r_trig     <= (w_next == ST_ENTRY_WAIT) || (w_next == ST_SIREN);
            r_alarm_go <= (w_next == ST_SIREN);
            r_siren    <= (w_next == ST_SIREN);
            r_lockout  <= (w_next == ST_LOCKED);
        end
    end

    assign arm_o    = r_arm;
    assign trig_o   = r_trig;
    assign alarm_go = r_alarm_go;
    assign siren    = r_siren;
    assign lockout  = r_lockout;
    assign zone_hit = r_zone_hit;
    assign bad_cnt  = r_bad;
    assign state_o  = r_state;

endmodule

// File: tb/tb_alarm_arm_sequencer.sv
module tb_alarm_arm_sequencer;

  localparam int ZONES     = 4;
  localparam int CODE_W    = 4;
  localparam int EXIT_DLY  = 8;
  localparam int ENTRY_DLY = 8;
  localparam int SIREN_CYC = 16;
  localparam int MAX_TRIES = 3;
  localparam int LOCK_CYC  = 32;
  localparam int BAD_W     = $clog2(MAX_TRIES+1);
  localparam int VEC_W     = 3 + 5 + ZONES + BAD_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              code_valid;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] secret;
  logic [ZONES-1:0]  zone;
  logic [ZONES-1:0]  zone_mask;
  logic              arm_o, trig_o, alarm_go, siren, lockout;
  logic [ZONES-1:0]  zone_hit;
  logic [BAD_W-1:0]  bad_cnt;
  logic [2:0]        state_o;

  always #5 clk = ~clk;

  alarm_arm_sequencer #(
    .ZONES(ZONES), .CODE_W(CODE_W), .EXIT_DLY(EXIT_DLY), .ENTRY_DLY(ENTRY_DLY),
    .SIREN_CYC(SIREN_CYC), .MAX_TRIES(MAX_TRIES), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
    .secret(secret), .zone(zone), .zone_mask(zone_mask),
    .arm_o(arm_o), .trig_o(trig_o), .alarm_go(alarm_go), .siren(siren),
    .lockout(lockout), .zone_hit(zone_hit), .bad_cnt(bad_cnt), .state_o(state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  // Mode numbers: 0 disarmed, 1 exit wait, 2 armed, 3 entry wait, 4 siren, 5 locked.
  // m_left counts cycles of residency still owed in a timed mode.
  int arm_tbl  [0:5] = '{0, 0, 1, 1, 1, 0};
  int trig_tbl [0:5] = '{0, 0, 0, 1, 1, 0};
  int sir_tbl  [0:5] = '{0, 0, 0, 0, 1, 0};
  int lock_tbl [0:5] = '{0, 0, 0, 0, 0, 1};

  int               m_mode = 0;
  int               m_left = 0;
  int               m_bad  = 0;
  logic [ZONES-1:0] m_hit  = '0;
  bit               m_started = 0;
  logic [VEC_W-1:0] exp_q[$];

  function automatic logic [VEC_W-1:0] pack_exp(input int mode, input logic [ZONES-1:0] hit,
                                                 input int bad);
    return {3'(mode), 1'(arm_tbl[mode]), 1'(trig_tbl[mode]), 1'(sir_tbl[mode]),
            1'(sir_tbl[mode]), 1'(lock_tbl[mode]), hit, BAD_W'(bad)};
  endfunction

  task automatic model_step();
    bit               match, wrong, expired, escalated;
    logic [ZONES-1:0] act;
    int               nmode, nleft;
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_bad = 0; m_hit = '0;
      return;
    end
    match   = code_valid && (code == secret);
    wrong   = code_valid && (code != secret);
    act     = zone & zone_mask;
    expired = (m_left <= 1);
    nmode   = m_mode;
    nleft   = (m_left > 0) ? m_left - 1 : 0;
    if (m_mode == 0) begin
      if (match) begin
        nmode = 1; nleft = EXIT_DLY; m_bad = 0;
      end else if (wrong) begin
        m_bad = (m_bad + 1 > MAX_TRIES) ? MAX_TRIES : m_bad + 1;
        if (m_bad == MAX_TRIES) begin
          nmode = 5; nleft = LOCK_CYC;
        end
      end
    end else if (m_mode == 5) begin
      if (expired) begin
        nmode = 0; m_bad = 0;
      end
    end else if (match) begin
      nmode = 0; m_bad = 0; m_hit = '0;
    end else begin
      escalated = 0;
      if (wrong) begin
        m_bad = (m_bad + 1 > MAX_TRIES) ? MAX_TRIES : m_bad + 1;
        if (m_bad == MAX_TRIES && m_mode != 4) begin
          nmode = 4; nleft = SIREN_CYC; escalated = 1;
        end
      end
      if (!escalated) begin
        if (m_mode == 1 && expired) nmode = 2;
        else if (m_mode == 2 && act != '0) begin
          nmode = 3; nleft = ENTRY_DLY; m_hit = m_hit | act;
        end else if (m_mode == 3) begin
          m_hit = m_hit | act;
          if (expired) begin
            nmode = 4; nleft = SIREN_CYC;
          end
        end else if (m_mode == 4 && expired) nmode = 2;
      end
    end
    m_mode = nmode;
    m_left = nleft;
  endtask

  always @(posedge clk) begin
    model_step();
    exp_q.push_back(pack_exp(m_mode, m_hit, m_bad));
    m_started = 1;
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    logic [VEC_W-1:0] exp_v, got_v;
    if (m_started) begin
      got_v = {state_o, arm_o, trig_o, alarm_go, siren, lockout, zone_hit, bad_cnt};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cycle_vec t=%0t got=%h required=<no expectation>", $time, got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_vec t=%0t got=%h required=%h", $time, got_v, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic enter_code(input logic [CODE_W-1:0] c);
    code_valid = 1'b1;
    code       = c;
    tick();
    code_valid = 1'b0;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    rst_n = 1'b0; code_valid = 1'b0; code = '0; secret = 4'hA;
    zone = '0; zone_mask = 4'b1111;
    tick(2);
    check("reset_state", 32'(state_o), 0);
    check("reset_outs", 32'({arm_o, trig_o, alarm_go, siren, lockout}), 0);
    check("reset_hit_bad", 32'({zone_hit, bad_cnt}), 0);
    rst_n = 1'b1;
    tick();

    // Arm: exit delay is exactly EXIT_DLY cycles, zones ignored meanwhile.
    enter_code(4'hA);
    check("exit_enter", 32'(state_o), 1);
    zone = 4'b0001;
    tick(EXIT_DLY - 1);
    check("exit_last", 32'(state_o), 1);
    tick();
    zone = '0;
    check("armed_state", 32'(state_o), 2);
    check("armed_arm", 32'(arm_o), 1);
    check("armed_hit", 32'(zone_hit), 0);

    // Masked zone has no effect.
    zone_mask = 4'b1011; zone = 4'b0100;
    tick(3);
    check("masked_state", 32'(state_o), 2);
    check("masked_hit", 32'(zone_hit), 0);
    zone = '0; zone_mask = 4'b1111;

    // Entry delay, then bounded siren, then back to armed.
    zone = 4'b0100;
    tick();
    zone = '0;
    check("entry_state", 32'(state_o), 3);
    check("entry_trig", 32'(trig_o), 1);
    check("entry_hit", 32'(zone_hit), 4'b0100);
    tick(ENTRY_DLY - 1);
    check("entry_last", 32'(state_o), 3);
    tick();
    check("siren_state", 32'(state_o), 4);
    check("siren_go", 32'({alarm_go, siren}), 2'b11);
    tick(SIREN_CYC - 1);
    check("siren_last", 32'(state_o), 4);
    tick();
    check("rearm_state", 32'(state_o), 2);
    check("rearm_outs", 32'({arm_o, trig_o, alarm_go}), 3'b100);
    check("rearm_hit", 32'(zone_hit), 4'b0100);

    // Correct code on the final entry cycle wins over the siren transition.
    zone = 4'b0010;
    tick();
    zone = '0;
    check("entry2_hit", 32'(zone_hit), 4'b0110);
    tick(ENTRY_DLY - 1);
    enter_code(4'hA);
    check("disarm_state", 32'(state_o), 0);
    check("disarm_outs", 32'({arm_o, trig_o, alarm_go, siren, lockout}), 0);
    check("disarm_hit", 32'(zone_hit), 0);

    // Wrong codes in DISARMED lead to lockout; keypad ignored while locked.
    code_valid = 1'b1; code = 4'h3;
    tick();
    check("bad1", 32'(bad_cnt), 1);
    tick();
    check("bad2", 32'(bad_cnt), 2);
    tick();
    check("bad3", 32'(bad_cnt), 3);
    check("lock_state", 32'(state_o), 5);
    check("lock_out", 32'(lockout), 1);
    code = 4'hA;
    tick();
    code_valid = 1'b0;
    check("lock_ignore", 32'(state_o), 5);
    tick(LOCK_CYC - 2);
    check("lock_last", 32'(state_o), 5);
    tick();
    check("unlock_state", 32'(state_o), 0);
    check("unlock_bad", 32'(bad_cnt), 0);
    check("unlock_out", 32'(lockout), 0);

    // Wrong codes while armed escalate straight to siren; reset aborts it.
    enter_code(4'hA);
    tick(EXIT_DLY);
    check("arm2_state", 32'(state_o), 2);
    code_valid = 1'b1; code = 4'h3;
    tick(2);
    check("arm_bad2", 32'({state_o, bad_cnt}), {3'd2, 2'd2});
    tick();
    code_valid = 1'b0;
    check("esc_state", 32'(state_o), 4);
    check("esc_siren", 32'(siren), 1);
    check("esc_bad", 32'(bad_cnt), 3);
    tick(4);
    rst_n = 1'b0;
    tick();
    check("rst_state", 32'(state_o), 0);
    check("rst_outs", 32'({arm_o, trig_o, alarm_go, siren, lockout}), 0);
    check("rst_hit_bad", 32'({zone_hit, bad_cnt}), 0);
    rst_n = 1'b1;
    tick(2);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog t=%0t got=running required=finished", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
